// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline definitions for CPU-side pipeline stages.
//   pipe_state_e : occupancy state of a pipeline/skid register. The encoding
//                  equals the number of live entries, so it doubles as the
//                  occupancy count.
//   OCC_W        : width of an occupancy count (0..2).
package cpu_pipe_pkg;

  localparam int OCC_W = 2;

  typedef enum logic [OCC_W-1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } pipe_state_e;

endpackage

// File: rtl/pipe_skid_reg.sv
// Pipeline register with optional skid buffer.
//   SKID=1 : 2-entry buffer (main + skid); in_ready comes straight from a
//            flop, so out_ready has no combinational path to in_ready.
//   SKID=0 : 1-entry register; in_ready = (!out_valid | out_ready) & !hold.
// Ports:
//   clk, rst            : clock, async active-high reset
//   in_valid/in_ready/in_data    : upstream handshake
//   out_valid/out_ready/out_data : downstream handshake; out_data shows
//                                  BUBBLE_VAL when out_valid=0
//   flush               : synchronous discard of all entries
//   hold                : freeze all state (wins over flush)
//   occupancy           : number of live entries, 0..2
module pipe_skid_reg
  import cpu_pipe_pkg::*;
#(
  parameter int                DATA_W     = 64,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = '0,
  parameter bit                SKID       = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  input  logic              hold,
  output logic [OCC_W-1:0]  occupancy
);

  pipe_state_e       state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic              in_fire, out_fire;

  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = out_valid ? main_q : BUBBLE_VAL;
  assign occupancy = state_q;   // encoding is the entry count

  assign in_fire  = in_valid  & in_ready  & ~hold & ~flush;
  assign out_fire = out_valid & out_ready & ~hold & ~flush;

  // Control state is reset; payload is never cleared, out_data masks it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_EMPTY;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    main_q <= main_d;
  end

  generate
    if (SKID) begin : g_skid
      logic [DATA_W-1:0] skid_q, skid_d;
      logic              rdy_q;

      always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (!hold) begin
          if (flush) begin
            state_d = ST_EMPTY;
          end else begin
            unique case (state_q)
              ST_EMPTY: if (in_fire) begin
                state_d = ST_ONE;
                main_d  = in_data;
              end
              ST_ONE: begin
                if (in_fire && out_fire) begin
                  main_d = in_data;
                end else if (in_fire) begin
                  state_d = ST_TWO;
                  skid_d  = in_data;
                end else if (out_fire) begin
                  state_d = ST_EMPTY;
                end
              end
              // in_ready is low in TWO, so only a drain can happen here.
              ST_TWO: if (out_fire) begin
                state_d = ST_ONE;
                main_d  = skid_q;
              end
              default: state_d = ST_EMPTY;
            endcase
          end
        end
      end

      // Registered ready looks ahead at the next state, so it is already low
      // in the cycle the buffer becomes full.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) rdy_q <= 1'b0;
        else     rdy_q <= (state_d != ST_TWO) & ~hold;
      end

      always_ff @(posedge clk) begin
        skid_q <= skid_d;
      end

      assign in_ready = rdy_q;

    end else begin : g_noskid

      always_comb begin
        state_d = state_q;
        main_d  = main_q;
        if (!hold) begin
          if (flush) begin
            state_d = ST_EMPTY;
          end else if (in_fire) begin
            // Accepting while full implies the head leaves this same edge.
            state_d = ST_ONE;
            main_d  = in_data;
          end else if (out_fire) begin
            state_d = ST_EMPTY;
          end
        end
      end

      assign in_ready = (~out_valid | out_ready) & ~hold & ~rst;

    end
  endgenerate

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 64: payload width in bits.
REQ-002 SHALL have parameter BUBBLE_VAL, default '0 (DATA_W bits): value driven on out_data when out_valid=0.
REQ-003 SHALL have parameter SKID, default 1: 1 selects 2-entry skid buffer with registered in_ready; 0 selects 1-entry register with combinational in_ready.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port in_valid, input, 1: upstream offers in_data.
REQ-007 SHALL have port in_ready, output, 1: block accepts in_data this cycle.
REQ-008 SHALL have port in_data, input, DATA_W: upstream payload.
REQ-009 SHALL have port out_valid, output, 1: out_data holds a live entry.
REQ-010 SHALL have port out_ready, input, 1: downstream accepts out_data.
REQ-011 SHALL have port out_data, output, DATA_W: head-entry payload, or BUBBLE_VAL.
REQ-012 SHALL have port flush, input, 1: synchronous discard of all entries (branch taken / hazard).
REQ-013 SHALL have port hold, input, 1: global freeze (bus stall); no state change.
REQ-014 SHALL have port occupancy, output, 2: live entry count, 0..2.

Function
REQ-015 SHALL define in-fire = in_valid & in_ready & !hold & !flush, and out-fire = out_valid & out_ready & !hold & !flush.
REQ-016 SHALL, for SKID=1, implement states EMPTY, ONE, TWO, with head register main and overflow register skid.
REQ-017 SHALL, in EMPTY: in-fire -> ONE with main<=in_data; otherwise stay in EMPTY.
REQ-018 SHALL, in ONE: in-fire and out-fire -> ONE with main<=in_data; in-fire only -> TWO with skid<=in_data; out-fire only -> EMPTY; neither -> stay in ONE.
REQ-019 SHALL, in TWO: out-fire -> ONE with main<=skid; otherwise stay in TWO; in-fire is impossible in TWO.
REQ-020 SHALL, for SKID=1, drive in_ready from a flop equal to (next state != TWO) & !hold, with no combinational path from out_ready.
REQ-021 SHALL, for SKID=0, use states EMPTY and ONE only, with in_ready = (!out_valid | out_ready) & !hold.
REQ-022 SHALL have 1-cycle latency: a word accepted at edge N is presented on out_valid/out_data after edge N.
REQ-023 SHALL sustain 1 word per cycle while in_valid=1 and out_ready=1, in both modes.
REQ-024 SHALL preserve order, with no loss or duplication of accepted words.
REQ-025 SHALL give priority rst > hold > flush > handshake; hold freezes all registers, including while flush=1.
REQ-026 SHALL, on flush without hold, go to EMPTY, discard in_data presented that cycle, and set out_valid=0 after the edge.
REQ-027 SHALL drive out_data = main when out_valid=1, else BUBBLE_VAL; payload registers need not be cleared.
REQ-028 SHALL keep out_valid and out_data stable while out_valid=1 and out-fire=0.
REQ-029 SHALL set occupancy = 0/1/2 for EMPTY/ONE/TWO.

Reset
REQ-030 SHALL, while rst=1, asynchronously force state EMPTY, out_valid=0, out_data=BUBBLE_VAL and occupancy=0.
REQ-031 SHALL force in_ready=0 while rst=1 and drive in_ready=1 from the first edge after release.
REQ-032 SHALL treat reset asserted mid-transfer as discarding all entries, with no partial update.

Structure
REQ-033 SHALL take the state enum (EMPTY, ONE, TWO) from shared package cpu_pipe_pkg, alongside the occupancy width constant.
REQ-034 SHALL be a single module with no sub-module; the SKID selection SHALL use a generate branch.

Verification
REQ-035 SHALL cover streaming: SKID=1, in_valid=1 with data 0x1,0x2,0x3, out_ready=1 -> out_data 0x1,0x2,0x3 on consecutive cycles, occupancy=1.
REQ-036 SHALL cover backpressure: SKID=1, out_ready=0, push 0xA then 0xB -> occupancy=2, in_ready=0; raise out_ready -> 0xA then 0xB out, in_ready returns to 1.
REQ-037 SHALL cover flush: occupancy=2 (0xA,0xB), flush=1 with in_valid=1 and data 0xC -> next cycle out_valid=0, out_data=BUBBLE_VAL, 0xC never appears.
REQ-038 SHALL cover hold over flush: hold=1 and flush=1 for 3 cycles with 0x5 held -> out_data stays 0x5, out_valid stays 1, occupancy unchanged; drop both -> 0x5 drains.
REQ-039 SHALL cover SKID=0 mode: out_valid=1, out_ready=1, in_valid=1 with 0x7 -> in_ready=1 in the same cycle and 0x7 is presented next cycle.
REQ-040 SHALL cover async reset: assert rst mid-cycle at occupancy=2 -> out_valid=0 and occupancy=0 before the next edge.
